rgb_to_gray_stream: RTL and testbench

RGB_TO_GRAY_STREAM -- requirements
Module: rgb_to_gray_stream

---
 rtl/rgb_to_gray_stream.sv | 120 ++++++++++++
 tb/tb_rgb_to_gray_stream.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_gray_stream.sv
// RGB888 to 8-bit luminance, two-stage pipeline, with frame position tracking
// and frame-alignment error detection carried alongside each pixel.
module rgb_to_gray_stream #(
   parameter int IMAGE_WIDTH  = 320,
   parameter int IMAGE_HEIGHT = 240
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rgb_valid,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   input  logic        sof_in,
   output logic        gray_valid,
   output logic [7:0]  gray,
   output logic [15:0] row,
   output logic [15:0] col,
   output logic        sof,
   output logic        eol,
   output logic        eof,
   output logic        frame_err
);

   localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
   localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

   logic [15:0] cnt_row, cnt_col;
   logic [15:0] pix_row, pix_col, nxt_row, nxt_col;
   logic        started, cnt_at_origin, pix_err;

   logic        v1;
   logic [16:0] p_r, p_g, p_b;
   logic [15:0] row1, col1;
   logic        err1;
   logic [16:0] sum;

   // sof_in forces the pixel to (0,0); errors only count once a frame has begun
   always_comb begin
      cnt_at_origin = (cnt_row == 16'd0) && (cnt_col == 16'd0);
      pix_row = cnt_row;
      pix_col = cnt_col;
      pix_err = 1'b0;
      if (sof_in) begin
         pix_row = '0;
         pix_col = '0;
         pix_err = started && !cnt_at_origin;
      end else begin
         pix_err = started && cnt_at_origin;
      end
      if (pix_col == LAST_COL) begin
         nxt_col = '0;
         nxt_row = (pix_row == LAST_ROW) ? 16'd0 : pix_row + 16'd1;
      end else begin
         nxt_col = pix_col + 16'd1;
         nxt_row = pix_row;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_row <= '0;
         cnt_col <= '0;
         started <= 1'b0;
      end else if (rgb_valid) begin
         cnt_row <= nxt_row;
         cnt_col <= nxt_col;
         if (sof_in) started <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         p_r  <= '0;
         p_g  <= '0;
         p_b  <= '0;
         row1 <= '0;
         col1 <= '0;
         err1 <= 1'b0;
      end else begin
         v1 <= rgb_valid;
         if (rgb_valid) begin
            p_r  <= 17'(r) * 17'd77;
            p_g  <= 17'(g) * 17'd150;
            p_b  <= 17'(b) * 17'd29;
            row1 <= pix_row;
            col1 <= pix_col;
            err1 <= pix_err;
         end
      end
   end

   // Coefficients sum to 256, so the rounded result never exceeds 255
   assign sum = p_r + p_g + p_b + 17'd128;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_valid <= 1'b0;
         gray       <= '0;
         row        <= '0;
         col        <= '0;
         sof        <= 1'b0;
         eol        <= 1'b0;
         eof        <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         gray_valid <= v1;
         sof        <= v1 && (row1 == 16'd0) && (col1 == 16'd0);
         eol        <= v1 && (col1 == LAST_COL);
         eof        <= v1 && (col1 == LAST_COL) && (row1 == LAST_ROW);
         frame_err  <= v1 && err1;
         if (v1) begin
            gray <= 8'(sum >> 8);
            row  <= row1;
            col  <= col1;
         end
      end
   end

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Directed bench for rgb_to_gray_stream on a reduced 8x12 frame; a scoreboard
// queue holds the expected output of every tracked pixel with its due cycle.
module tb_rgb_to_gray_stream;

   localparam int W = 8;
   localparam int H = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rgb_valid = 1'b0;
   logic [7:0]  r = '0, g = '0, b = '0;
   logic        sof_in = 1'b0;
   logic        gray_valid;
   logic [7:0]  gray;
   logic [15:0] row, col;
   logic        sof, eol, eof, frame_err;

   rgb_to_gray_stream #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .rgb_valid(rgb_valid), .r(r), .g(g), .b(b),
      .sof_in(sof_in), .gray_valid(gray_valid), .gray(gray), .row(row),
      .col(col), .sof(sof), .eol(eol), .eof(eof), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  gray;
      logic [15:0] row;
      logic [15:0] col;
      logic        sof, eol, eof, err;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0, failures = 0, cyc = 0;
   int n_strobe = 0, n_eol = 0, n_eof = 0, n_sof = 0, n_err = 0;
   logic [7:0]  last_gray = '0;
   logic [15:0] last_row = '0, last_col = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] gray_ref(input int rv, input int gv, input int bv);
      return 8'((77 * rv + 150 * gv + 29 * bv + 128) >> 8);
   endfunction

   // egray < 0 means derive the expected luminance from the formula
   task automatic send(input int rv, input int gv, input int bv, input bit s,
                       input bit track, input int egray, input int er, input int ec,
                       input bit eerr);
      exp_t e;
      @(posedge clk); #1;
      rgb_valid = 1'b1;
      r = 8'(rv); g = 8'(gv); b = 8'(bv);
      sof_in = s;
      if (track) begin
         e.gray = (egray < 0) ? gray_ref(rv, gv, bv) : 8'(egray);
         e.row  = 16'(er);
         e.col  = 16'(ec);
         e.sof  = (er == 0) && (ec == 0);
         e.eol  = (ec == W - 1);
         e.eof  = (ec == W - 1) && (er == H - 1);
         e.err  = eerr;
         e.cyc  = cyc + 2;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         rgb_valid = 1'b0;
         sof_in = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rgb_valid = 1'b0;
      sof_in = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clear_stats();
      n_strobe = 0; n_eol = 0; n_eof = 0; n_sof = 0; n_err = 0;
   endtask

   task automatic frame(input int gap);
      for (int rr = 0; rr < H; rr++)
         for (int cc = 0; cc < W; cc++) begin
            send((cc * 29 + rr * 7) & 255, (cc * 13 + rr * 31 + 5) & 255,
                 (255 - cc * 17 - rr * 3) & 255, (rr == 0 && cc == 0), 1'b1, -1,
                 rr, cc, 1'b0);
            idle(gap);
         end
      idle(4);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         last_gray = '0; last_row = '0; last_col = '0;
      end else if (gray_valid) begin
         n_strobe++;
         if (eol) n_eol++;
         if (eof) n_eof++;
         if (sof) n_sof++;
         if (frame_err) n_err++;
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("latency", cyc, e.cyc);
            chk("gray", gray, e.gray);
            chk("row", row, e.row);
            chk("col", col, e.col);
            chk("sof", sof, e.sof);
            chk("eol", eol, e.eol);
            chk("eof", eof, e.eof);
            chk("frame_err", frame_err, e.err);
         end
         last_gray = gray; last_row = row; last_col = col;
      end else begin
         chk("idle_flags", {sof, eol, eof, frame_err}, 0);
         chk("hold_gray", gray, last_gray);
         chk("hold_pos", {row, col}, {last_row, last_col});
      end
   end

   initial begin
      #1;
      chk("rst_outputs", {gray_valid, gray, row, col, sof, eol, eof, frame_err}, 0);
      do_reset();

      // white pixel with sof_in
      send(255, 255, 255, 1'b1, 1'b1, 255, 0, 0, 1'b0);
      idle(4);

      // primaries back-to-back, numbered from (0,0) without sof
      do_reset();
      send(100, 0, 0, 1'b0, 1'b1, 30, 0, 0, 1'b0);
      send(0, 100, 0, 1'b0, 1'b1, 59, 0, 1, 1'b0);
      send(0, 0, 100, 1'b0, 1'b1, 11, 0, 2, 1'b0);
      idle(4);

      // two pixels in flight when reset hits
      send(200, 10, 10, 1'b0, 1'b0, -1, 0, 0, 1'b0);
      send(50, 60, 70, 1'b0, 1'b0, -1, 0, 0, 1'b0);
      #2;
      rst_n = 1'b0;
      rgb_valid = 1'b0;
      #1;
      chk("rst_async_clear", {gray_valid, gray, row, col, sof, eol, eof, frame_err}, 0);
      @(posedge clk); #1;
      chk("rst_held_valid", gray_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(10, 20, 30, 1'b0, 1'b1, 18, 0, 0, 1'b0);
      send(200, 200, 200, 1'b0, 1'b1, 200, 0, 1, 1'b0);
      idle(6);

      // full frame continuous, then the next one sparse
      do_reset();
      clear_stats();
      frame(0);
      chk("strobes_cont", n_strobe, W * H);
      chk("eol_cont", n_eol, H);
      chk("eof_cont", n_eof, 1);
      chk("sof_cont", n_sof, 1);
      chk("err_cont", n_err, 0);
      clear_stats();
      frame(5);
      chk("strobes_gap", n_strobe, W * H);
      chk("eol_gap", n_eol, H);
      chk("eof_gap", n_eof, 1);
      chk("sof_gap", n_sof, 1);
      chk("err_gap", n_err, 0);

      // early sof at (10,5), then a frame-wrap pixel with missing sof
      do_reset();
      clear_stats();
      for (int k = 0; k < 10 * W + 5; k++)
         send(k & 255, 40, 90, (k == 0), 1'b1, -1, k / W, k % W, 1'b0);
      send(90, 90, 90, 1'b1, 1'b1, 90, 0, 0, 1'b1);
      for (int k = 1; k < W * H; k++)
         send(30, (k * 3) & 255, 60, 1'b0, 1'b1, -1, k / W, k % W, 1'b0);
      send(0, 0, 0, 1'b0, 1'b1, 0, 0, 0, 1'b1);
      send(1, 1, 1, 1'b0, 1'b1, 1, 0, 1, 1'b0);
      idle(5);
      chk("err_count", n_err, 2);
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
